// File: rtl/core_seq_if.sv
// Valid/ready input stream carrying Q/K vectors into the attention-core sequencer.
interface core_seq_if #(
    parameter int unsigned W = 64
) ();
    logic [W-1:0] in_data;
    logic         in_valid;
    logic         in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/core_seq.sv
// Attention-tile sequencer: fetches Q/K, writes q/kmem, loads kernel, executes,
// drains the OFIFO into psum memory and reads psum back with an aligned strobe.
module core_seq #(
    parameter int unsigned bw           = 8,
    parameter int unsigned pr           = 8,
    parameter int unsigned col          = 8,
    parameter int unsigned total_cycle  = 8,
    parameter int unsigned gap_cycles   = 8,
    parameter int unsigned drain_cycles = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    core_seq_if.slave          bus,
    output logic [16:0]        inst,
    output logic [pr*bw-1:0]   mem_in,
    output logic               sum_valid,
    output logic [3:0]         sum_idx,
    output logic               busy,
    output logic               done
);
    localparam int unsigned DW = pr * bw;
    localparam int unsigned CW = 8;
    localparam int unsigned IW = 17;

    localparam int unsigned B_OFRD = 16;
    localparam int unsigned B_EXE  = 7;
    localparam int unsigned B_KLD  = 6;
    localparam int unsigned B_QRD  = 5;
    localparam int unsigned B_QWR  = 4;
    localparam int unsigned B_KRD  = 3;
    localparam int unsigned B_KWR  = 2;
    localparam int unsigned B_PRD  = 1;
    localparam int unsigned B_PWR  = 0;

    localparam logic [CW-1:0] TC_LAST  = CW'(total_cycle - 1);
    localparam logic [CW-1:0] TC_END   = CW'(total_cycle);
    localparam logic [CW-1:0] COL_LAST = CW'(col - 1);
    localparam logic [CW-1:0] COL_END  = CW'(col);
    localparam logic [CW-1:0] GAP_LAST = CW'(gap_cycles - 1);
    localparam logic [CW-1:0] DRN_LAST = CW'(drain_cycles - 1);
    localparam logic [CW-1:0] WAIT_LAST = CW'(1);

    typedef enum logic [3:0] {
        S_IDLE, S_QWR, S_KWR, S_KLD, S_GAP, S_EXE,
        S_DRAIN, S_OFRD, S_PRD, S_WAIT, S_DONE
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [IW-1:0]   inst_q, inst_d;
    logic [DW-1:0]   mem_in_q, mem_in_d;
    logic            in_ready_q, in_ready_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            rd_dly_q, rd_dly_d;
    logic [3:0]      rd_idx_q, rd_idx_d;
    logic            sum_valid_q, sum_valid_d;
    logic [3:0]      sum_idx_q, sum_idx_d;

    logic [3:0]      addr;
    logic            xfer;

    assign addr = cnt_q[3:0];
    assign xfer = bus.in_valid && in_ready_q;

    // Next state, counter and registered-output computation.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + CW'(1);
        inst_d   = '0;
        mem_in_d = mem_in_q;
        done_d   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (start) state_d = S_QWR;
            end
            S_QWR: begin
                cnt_d = cnt_q;
                if (xfer) begin
                    inst_d[B_QWR]  = 1'b1;
                    inst_d[15:12]  = addr;
                    mem_in_d       = bus.in_data;
                    if (cnt_q == TC_LAST) begin
                        state_d = S_KWR;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            S_KWR: begin
                cnt_d = cnt_q;
                if (xfer) begin
                    inst_d[B_KWR]  = 1'b1;
                    inst_d[15:12]  = addr;
                    mem_in_d       = bus.in_data;
                    if (cnt_q == COL_LAST) begin
                        state_d = S_KLD;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            S_KLD: begin
                // Extra final cycle keeps kernel-load high across the kmem read latency.
                inst_d[B_KLD] = 1'b1;
                if (cnt_q < COL_END) begin
                    inst_d[B_KRD] = 1'b1;
                    inst_d[15:12] = addr;
                end else begin
                    state_d = S_GAP;
                    cnt_d   = '0;
                end
            end
            S_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = S_EXE;
                    cnt_d   = '0;
                end
            end
            S_EXE: begin
                inst_d[B_EXE] = 1'b1;
                if (cnt_q < TC_END) begin
                    inst_d[B_QRD] = 1'b1;
                    inst_d[15:12] = addr;
                end else begin
                    state_d = S_DRAIN;
                    cnt_d   = '0;
                end
            end
            S_DRAIN: begin
                if (cnt_q == DRN_LAST) begin
                    state_d = S_OFRD;
                    cnt_d   = '0;
                end
            end
            S_OFRD: begin
                inst_d[B_OFRD] = 1'b1;
                inst_d[B_PWR]  = 1'b1;
                inst_d[11:8]   = addr;
                if (cnt_q == TC_LAST) begin
                    state_d = S_PRD;
                    cnt_d   = '0;
                end
            end
            S_PRD: begin
                inst_d[B_PRD] = 1'b1;
                inst_d[11:8]  = addr;
                if (cnt_q == TC_LAST) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end
            end
            S_WAIT: begin
                if (cnt_q == WAIT_LAST) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                cnt_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        busy_d     = (state_d != S_IDLE);
        in_ready_d = (state_d == S_QWR) || (state_d == S_KWR);

        // Two-stage strobe: one cycle of psum SRAM latency, one of the sum_out register.
        rd_dly_d    = inst_q[B_PRD];
        rd_idx_d    = inst_q[B_PRD] ? inst_q[11:8] : 4'd0;
        sum_valid_d = rd_dly_q;
        sum_idx_d   = rd_idx_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            inst_q      <= '0;
            mem_in_q    <= '0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rd_dly_q    <= 1'b0;
            rd_idx_q    <= '0;
            sum_valid_q <= 1'b0;
            sum_idx_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            inst_q      <= inst_d;
            mem_in_q    <= mem_in_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            rd_dly_q    <= rd_dly_d;
            rd_idx_q    <= rd_idx_d;
            sum_valid_q <= sum_valid_d;
            sum_idx_q   <= sum_idx_d;
        end
    end

    assign bus.in_ready = in_ready_q;
    assign inst         = inst_q;
    assign mem_in       = mem_in_q;
    assign sum_valid    = sum_valid_q;
    assign sum_idx      = sum_idx_q;
    assign busy         = busy_q;
    assign done         = done_q;
endmodule

// File: tb/tb_core_seq.sv
// Bench for core_seq: table of tiles (nominal, stalled, random, start-while-busy),
// schedule-level reference model, plus reset and reset-mid-execute sequences.
module tb_core_seq;
    localparam int unsigned BW = 8, PR = 8, COL = 8, TC = 8, GAP = 8, DRN = 10;
    localparam int unsigned DW = PR * BW;
    localparam int MAXC = 256;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [16:0]   inst;
    logic [DW-1:0] mem_in;
    logic          sum_valid;
    logic [3:0]    sum_idx;
    logic          busy;
    logic          done;

    core_seq_if #(.W(DW)) bus ();

    core_seq #(.bw(BW), .pr(PR), .col(COL), .total_cycle(TC),
               .gap_cycles(GAP), .drain_cycles(DRN)) dut (
        .clk(clk), .reset(reset), .start(start), .bus(bus),
        .inst(inst), .mem_in(mem_in), .sum_valid(sum_valid), .sum_idx(sum_idx),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic          vld_a [MAXC];
    logic [DW-1:0] dat_a [MAXC];
    logic [16:0]   a_inst [MAXC], e_inst [MAXC];
    logic [DW-1:0] a_mem [MAXC], e_mem [MAXC];
    logic [3:0]    a_idx [MAXC], e_idx [MAXC];
    logic          a_sv [MAXC], e_sv [MAXC];
    logic          a_busy [MAXC], e_busy [MAXC];
    logic          a_rdy [MAXC], e_rdy [MAXC];
    logic          a_done [MAXC], e_done [MAXC];
    logic [DW-1:0] mem_hold;
    int            rec_len;
    int            e_done_at;

    typedef struct {
        int mode;      // 0: valid always, 1: valid on even cycles only, 2: random
        int start_at;  // extra start pulse cycle (-1 none)
        int exp_done;  // expected done cycle after start (-1: from model only)
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic pat(input int mode, input int t);
        case (mode)
            0:       return 1'b1;
            1:       return (t % 2) == 0;
            default: return $urandom_range(0, 3) != 0;
        endcase
    endfunction

    task automatic run_tile(input int mode, input int start_at, output int done_cyc, output int n_done);
        done_cyc = -1;
        n_done   = 0;
        rec_len  = 0;
        for (int t = 0; t < MAXC; t++) begin
            @(posedge clk); #1;
            start        = (t == 0) || (t == start_at);
            bus.in_valid = pat(mode, t);
            bus.in_data  = {$urandom, $urandom};
            vld_a[t]     = bus.in_valid;
            dat_a[t]     = bus.in_data;
            @(negedge clk);
            a_inst[t] = inst;      a_mem[t]  = mem_in;  a_sv[t]   = sum_valid;
            a_idx[t]  = sum_idx;   a_busy[t] = busy;    a_rdy[t]  = bus.in_ready;
            a_done[t] = done;
            if (done) begin
                n_done++;
                if (done_cyc < 0) done_cyc = t;
            end
            rec_len = t + 1;
            if (done_cyc >= 0 && t >= done_cyc + 3) break;
        end
        start        = 1'b0;
        bus.in_valid = 1'b0;
    endtask

    task automatic set_inst(input int t, input logic [16:0] v);
        if (t >= 0 && t < MAXC) e_inst[t] = v;
    endtask

    // Expected schedule: accepted beats, then fixed-length phases back to back.
    task automatic build_model();
        int            beats, w_end, b;
        int            acc_t [TC+COL];
        logic [DW-1:0] acc_d [TC+COL];
        logic [DW-1:0] cur;
        beats = 0;
        w_end = -1;
        for (int t = 0; t < MAXC; t++) begin
            e_inst[t] = '0; e_sv[t] = 1'b0; e_idx[t] = '0; e_busy[t] = 1'b0;
            e_rdy[t] = 1'b0; e_done[t] = 1'b0;
        end
        for (int t = 1; t < rec_len && beats < int'(TC + COL); t++) begin
            e_rdy[t] = 1'b1;
            if (vld_a[t]) begin
                acc_t[beats] = t;
                acc_d[beats] = dat_a[t];
                if (beats < int'(TC)) set_inst(t + 1, 17'h00010 | (17'(beats) << 12));
                else                  set_inst(t + 1, 17'h00004 | (17'(beats - int'(TC)) << 12));
                beats++;
                if (beats == int'(TC + COL)) w_end = t;
            end
        end
        cur = mem_hold;
        for (int t = 0; t < MAXC; t++) begin
            for (int j = 0; j < beats; j++)
                if (acc_t[j] + 1 == t) cur = acc_d[j];
            e_mem[t] = cur;
        end
        mem_hold  = cur;
        e_done_at = -1;
        if (w_end >= 0) begin
            b = w_end + 2;
            for (int i = 0; i <= int'(COL); i++)
                set_inst(b + i, 17'h00040 | ((i < int'(COL)) ? (17'h00008 | (17'(i) << 12)) : 17'h0));
            b += int'(COL) + 1 + int'(GAP);
            for (int i = 0; i <= int'(TC); i++)
                set_inst(b + i, 17'h00080 | ((i < int'(TC)) ? (17'h00020 | (17'(i) << 12)) : 17'h0));
            b += int'(TC) + 1 + int'(DRN);
            for (int i = 0; i < int'(TC); i++) set_inst(b + i, 17'h10001 | (17'(i) << 8));
            b += int'(TC);
            for (int i = 0; i < int'(TC); i++) begin
                set_inst(b + i, 17'h00002 | (17'(i) << 8));
                if (b + i + 2 < MAXC) begin
                    e_sv[b + i + 2]  = 1'b1;
                    e_idx[b + i + 2] = 4'(i);
                end
            end
            e_done_at = b + int'(TC) - 1 + 2 + 1;
            if (e_done_at < MAXC) e_done[e_done_at] = 1'b1;
            for (int t = 1; t < e_done_at && t < MAXC; t++) e_busy[t] = 1'b1;
        end
    endtask

    task automatic compare_trace(input string tag);
        int m_inst = 0, m_mem = 0, m_sv = 0, m_idx = 0, m_busy = 0, m_rdy = 0, m_done = 0;
        int f_inst = -1;
        for (int t = 0; t < rec_len; t++) begin
            if (a_inst[t] !== e_inst[t]) begin
                m_inst++;
                if (f_inst < 0) f_inst = t;
            end
            if (a_mem[t]  !== e_mem[t])  m_mem++;
            if (a_sv[t]   !== e_sv[t])   m_sv++;
            if (a_idx[t]  !== e_idx[t])  m_idx++;
            if (a_busy[t] !== e_busy[t]) m_busy++;
            if (a_rdy[t]  !== e_rdy[t])  m_rdy++;
            if (a_done[t] !== e_done[t]) m_done++;
        end
        check({tag, "_inst_mismatch_cycles"}, 64'(m_inst), 64'd0);
        if (f_inst >= 0)
            $display("  %s first inst diff at cycle %0d: got %05h want %05h", tag, f_inst, a_inst[f_inst], e_inst[f_inst]);
        check({tag, "_memin_mismatch_cycles"}, 64'(m_mem), 64'd0);
        check({tag, "_sumvalid_mismatch_cycles"}, 64'(m_sv), 64'd0);
        check({tag, "_sumidx_mismatch_cycles"}, 64'(m_idx), 64'd0);
        check({tag, "_busy_mismatch_cycles"}, 64'(m_busy), 64'd0);
        check({tag, "_inready_mismatch_cycles"}, 64'(m_rdy), 64'd0);
        check({tag, "_done_mismatch_cycles"}, 64'(m_done), 64'd0);
    endtask

    // Direct protocol properties of the observed trace.
    task automatic protocol_checks(input string tag);
        int kld = 0, kld_f = -1, kld_l = -1, krd = 0, exe = 0, exe_f = -1, exe_l = -1, qrd = 0;
        int of_split = 0, nq = 0, nk = 0, q_err = 0, k_err = 0, nsv = 0;
        for (int t = 0; t < rec_len; t++) begin
            if (a_inst[t][6]) begin kld++; if (kld_f < 0) kld_f = t; kld_l = t; end
            if (a_inst[t][3]) krd++;
            if (a_inst[t][7]) begin exe++; if (exe_f < 0) exe_f = t; exe_l = t; end
            if (a_inst[t][5]) qrd++;
            if (a_inst[t][16] != a_inst[t][0]) of_split++;
            if (a_inst[t][4]) begin if (int'(a_inst[t][15:12]) != nq) q_err++; nq++; end
            if (a_inst[t][2]) begin if (int'(a_inst[t][15:12]) != nk) k_err++; nk++; end
            if (a_sv[t]) nsv++;
        end
        check({tag, "_kld_len"}, 64'(kld), 64'(COL + 1));
        check({tag, "_kld_span"}, 64'(kld_l - kld_f + 1), 64'(COL + 1));
        check({tag, "_kmem_rd_len"}, 64'(krd), 64'(COL));
        check({tag, "_exe_len"}, 64'(exe), 64'(TC + 1));
        check({tag, "_exe_span"}, 64'(exe_l - exe_f + 1), 64'(TC + 1));
        check({tag, "_qmem_rd_len"}, 64'(qrd), 64'(TC));
        check({tag, "_ofrd_pmemwr_split"}, 64'(of_split), 64'd0);
        check({tag, "_qwr_count"}, 64'(nq), 64'(TC));
        check({tag, "_qwr_addr_errs"}, 64'(q_err), 64'd0);
        check({tag, "_kwr_count"}, 64'(nk), 64'(COL));
        check({tag, "_kwr_addr_errs"}, 64'(k_err), 64'd0);
        check({tag, "_sum_valid_pulses"}, 64'(nsv), 64'(TC));
    endtask

    task automatic do_tile(input vec_t v, input string tag);
        int done_cyc, n_done;
        run_tile(v.mode, v.start_at, done_cyc, n_done);
        build_model();
        if (done_cyc < 0) $display("FAIL %s_timeout: no done within %0d cycles", tag, MAXC);
        check({tag, "_done_cycle_model"}, 64'(done_cyc), 64'(e_done_at));
        if (v.exp_done >= 0) check({tag, "_done_cycle_table"}, 64'(done_cyc), 64'(v.exp_done));
        check({tag, "_done_pulses"}, 64'(n_done), 64'd1);
        compare_trace(tag);
        protocol_checks(tag);
    endtask

    initial begin
        vec_t vecs [5];
        vec_t clean;
        vecs[0] = '{mode: 0, start_at: -1, exp_done: 72};
        vecs[1] = '{mode: 1, start_at: -1, exp_done: 88};
        vecs[2] = '{mode: 0, start_at: 47, exp_done: 72};
        vecs[3] = '{mode: 2, start_at: -1, exp_done: -1};
        vecs[4] = '{mode: 2, start_at: -1, exp_done: -1};
        clean   = '{mode: 0, start_at: -1, exp_done: 72};

        reset = 1'b0; start = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0; mem_hold = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ctrl_outs", 64'({inst, sum_valid, sum_idx, busy, done, bus.in_ready}), 64'd0);
        check("reset_mem_in", mem_in, 64'd0);
        @(posedge clk); #1 reset = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_busy_ready", 64'({busy, bus.in_ready, inst}), 64'd0);

        for (int i = 0; i < 5; i++) do_tile(vecs[i], $sformatf("tile%0d", i));

        // Reset asserted in the middle of execute.
        for (int t = 0; t <= 38; t++) begin
            @(posedge clk); #1;
            start        = (t == 0);
            bus.in_valid = 1'b1;
            bus.in_data  = {$urandom, $urandom};
        end
        start = 1'b0;
        @(negedge clk);
        check("pre_reset_exe_inst", 64'(inst), 64'h030A0);
        #2 reset = 1'b0;
        #1;
        check("midreset_outs", 64'({inst, busy, sum_valid, bus.in_ready}), 64'd0);
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        mem_hold = '0;
        do_tile(clean, "post_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
